// File: rtl/ip_rom_arbiter.sv
// ip_rom_arbiter: shares the single-port IPL ROM between the CPU bus bridge
// (master 0) and the boot loader/copy engine (master 1). One read per clock,
// combinational grant, round-robin with a bounded burst lock, and in-order
// routing of the one-cycle-latency ROM data back to the issuing master.

// Per-master response path: claims the returned byte when this master owns
// the read that is in flight, and forces the data to zero otherwise.
module ip_rom_arbiter_resp #(
    parameter logic IDX = 1'b0
) (
    input  logic       i_rom_rdata_en,
    input  logic [7:0] i_rom_rdata,
    input  logic       i_pending,
    input  logic       i_owner,
    output logic       o_rdata_en,
    output logic [7:0] o_rdata
);
    assign o_rdata_en = i_rom_rdata_en & i_pending & (i_owner == IDX);
    assign o_rdata    = o_rdata_en ? i_rom_rdata : 8'h00;
endmodule

module ip_rom_arbiter #(
    parameter int LOCK_MAX = 16
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       m0_req,
    input  logic       m0_lock,
    input  logic [9:0] m0_address,
    output logic       m0_gnt,
    output logic [7:0] m0_rdata,
    output logic       m0_rdata_en,
    input  logic       m1_req,
    input  logic       m1_lock,
    input  logic [9:0] m1_address,
    output logic       m1_gnt,
    output logic [7:0] m1_rdata,
    output logic       m1_rdata_en,
    output logic       rom_n_cs,
    output logic       rom_n_rd,
    output logic [9:0] rom_address,
    input  logic [7:0] rom_rdata,
    input  logic       rom_rdata_en
);
    localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    // Saturation point of the lock counter; a holder keeps winning contested
    // cycles only while the counter is below this value.
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX - 1);

    logic          r_ready;
    logic          r_last;
    logic          r_locked;
    logic [CW-1:0] r_lock_cnt;
    logic          r_pending;
    logic          r_owner;

    logic [1:0]      w_req;
    logic [1:0]      w_lock;
    logic [1:0][9:0] w_addr;
    logic            w_hold;
    logic            w_acc;
    logic            w_win;
    logic [1:0]      w_rdata_en;
    logic [1:0][7:0] w_rdata;

    assign w_req  = {m1_req, m1_req & 1'b0} | {1'b0, m0_req};
    assign w_lock = {m1_lock, m0_lock};
    assign w_addr = {m1_address, m0_address};

    // The previous winner may keep the port under contention only while its
    // lock is active and its run has not reached the cap.
    assign w_hold = r_locked && (r_lock_cnt < CNT_MAX);

    // Winner selection: sole requester wins, ties go to the lock holder or
    // rotate away from the last winner.
    always_comb begin
        w_acc = 1'b0;
        w_win = 1'b0;
        if (r_ready) begin
            case (w_req)
                2'b01: begin
                    w_acc = 1'b1;
                    w_win = 1'b0;
                end
                2'b10: begin
                    w_acc = 1'b1;
                    w_win = 1'b1;
                end
                2'b11: begin
                    w_acc = 1'b1;
                    w_win = w_hold ? r_last : ~r_last;
                end
                default: begin
                    w_acc = 1'b0;
                    w_win = 1'b0;
                end
            endcase
        end
    end

    assign m0_gnt      = w_acc & ~w_win;
    assign m1_gnt      = w_acc & w_win;
    assign rom_n_cs    = ~w_acc;
    assign rom_n_rd    = ~w_acc;
    assign rom_address = w_acc ? w_addr[w_win] : 10'd0;

    // Hold off arbitration until the first edge after reset release.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) r_ready <= 1'b0;
        else          r_ready <= 1'b1;
    end

    // Fairness state: last winner, lock flag and saturating lock run count.
    // A different master taking a locked accept restarts the run at zero.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_last     <= 1'b1;
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
        end else if (w_acc) begin
            r_last <= w_win;
            if (!w_lock[w_win]) begin
                r_locked   <= 1'b0;
                r_lock_cnt <= '0;
            end else if (!r_locked || (r_last != w_win)) begin
                r_locked   <= 1'b1;
                r_lock_cnt <= '0;
            end else if (r_lock_cnt != CNT_MAX) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end
        end
    end

    // Track the read in flight; the async clear masks a late ROM response
    // when reset lands mid-read.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_pending <= 1'b0;
            r_owner   <= 1'b0;
        end else begin
            r_pending <= w_acc;
            if (w_acc) r_owner <= w_win;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_resp
        ip_rom_arbiter_resp #(
            .IDX(1'(g))
        ) u_resp (
            .i_rom_rdata_en(rom_rdata_en),
            .i_rom_rdata   (rom_rdata),
            .i_pending     (r_pending),
            .i_owner       (r_owner),
            .o_rdata_en    (w_rdata_en[g]),
            .o_rdata       (w_rdata[g])
        );
    end

    assign m0_rdata_en = w_rdata_en[0];
    assign m1_rdata_en = w_rdata_en[1];
    assign m0_rdata    = w_rdata[0];
    assign m1_rdata    = w_rdata[1];
endmodule

// File: tb/tb_ip_rom_arbiter.sv
// Bench for ip_rom_arbiter: directed scenarios then random two-master traffic.
// Grants are checked against a reference model in the same cycle; expected
// read responses go into a scoreboard queue that a separate monitor drains.
module tb_ip_rom_arbiter;
    localparam int LOCK_MAX = 4;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       m0_req, m0_lock, m1_req, m1_lock;
    logic [9:0] m0_address, m1_address;
    logic       m0_gnt, m1_gnt, m0_rdata_en, m1_rdata_en;
    logic [7:0] m0_rdata, m1_rdata;
    logic       rom_n_cs, rom_n_rd;
    logic [9:0] rom_address;
    logic [7:0] rom_rdata = 8'h00;
    logic       rom_rdata_en = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int         m;
        logic [7:0] d;
        int         due;
    } exp_t;
    exp_t q[$];

    // reference model state
    bit mdl_ready;
    int mdl_last;
    bit mdl_locked;
    int mdl_run;   // locked accepts in a row by mdl_last, unbounded

    ip_rom_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .n_reset(n_reset),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_address(m0_address),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rdata_en(m0_rdata_en),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_address(m1_address),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rdata_en(m1_rdata_en),
        .rom_n_cs(rom_n_cs), .rom_n_rd(rom_n_rd), .rom_address(rom_address),
        .rom_rdata(rom_rdata), .rom_rdata_en(rom_rdata_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_byte(input int a);
        if (a == 0) return 8'hF3;
        if (a == 1) return 8'h31;
        if (a < 4)  return 8'h00;
        return 8'((a * 37 + 11) ^ (a >> 2));
    endfunction

    // ROM: one-cycle registered read, deliberately not reset
    always @(posedge clk) begin
        rom_rdata_en <= !rom_n_cs && !rom_n_rd;
        if (!rom_n_cs && !rom_n_rd) rom_rdata <= rom_byte(int'(rom_address));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void mdl_reset();
        mdl_ready  = 1'b0;
        mdl_last   = 1;
        mdl_locked = 1'b0;
        mdl_run    = 0;
    endfunction

    // One clock of stimulus: drive after the edge, check grant/strobes at the
    // falling edge, queue the expected response, advance the model.
    task automatic step(input logic rn,
                        input logic r0, input logic l0, input logic [9:0] a0,
                        input logic r1, input logic l1, input logic [9:0] a1,
                        output int win);
        int          w;
        logic [9:0]  wa;
        logic        wl;
        @(posedge clk);
        if (n_reset) mdl_ready = 1'b1;
        #1;
        n_reset = rn;
        m0_req = r0; m0_lock = l0; m0_address = a0;
        m1_req = r1; m1_lock = l1; m1_address = a1;
        if (!rn) begin
            mdl_reset();
            while (q.size() > 0 && q[$].due == cyc) void'(q.pop_back());
        end
        w = -1;
        if (mdl_ready) begin
            if (r0 && r1)
                w = (mdl_locked && mdl_run < LOCK_MAX) ? mdl_last : 1 - mdl_last;
            else if (r0) w = 0;
            else if (r1) w = 1;
        end
        wa = (w == 1) ? a1 : a0;
        wl = (w == 1) ? l1 : l0;
        @(negedge clk);
        chk("grant", {30'd0, m1_gnt, m0_gnt},
            (w == 0) ? 32'd1 : (w == 1) ? 32'd2 : 32'd0);
        chk("rom_strobe_addr", {20'd0, rom_n_cs, rom_n_rd, rom_address},
            (w < 0) ? {20'd0, 2'b11, 10'd0} : {20'd0, 2'b00, wa});
        if (w >= 0) begin
            q.push_back('{m: w, d: rom_byte(int'(wa)), due: cyc + 1});
            if (!wl) begin
                mdl_locked = 1'b0;
                mdl_run    = 0;
            end else if (mdl_locked && mdl_last == w) begin
                mdl_run++;
            end else begin
                mdl_locked = 1'b1;
                mdl_run    = 1;
            end
            mdl_last = w;
        end
        win = w;
    endtask

    // Monitor: every cycle the responses must match the scoreboard head
    initial begin
        logic [1:0] exp_en;
        logic [7:0] e0, e1;
        exp_t       e;
        forever begin
            @(negedge clk);
            exp_en = 2'b00; e0 = 8'h00; e1 = 8'h00;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                exp_en[e.m] = 1'b1;
                if (e.m == 0) e0 = e.d;
                else          e1 = e.d;
            end
            chk("rdata_en", {30'd0, m1_rdata_en, m0_rdata_en}, {30'd0, exp_en});
            chk("m0_rdata", {24'd0, m0_rdata}, {24'd0, e0});
            chk("m1_rdata", {24'd0, m1_rdata}, {24'd0, e1});
        end
    end

    initial begin
        int         w;
        logic       hr0, hl0, hr1, hl1;
        logic [9:0] ha0, ha1;
        n_reset = 1'b0;
        m0_req = 0; m0_lock = 0; m0_address = '0;
        m1_req = 0; m1_lock = 0; m1_address = '0;
        mdl_reset();

        // reset held with both requesting, then release
        step(0, 1, 0, 10'd0, 1, 0, 10'd5, w);
        step(0, 1, 0, 10'd0, 1, 0, 10'd5, w);
        step(1, 1, 0, 10'd0, 1, 0, 10'd5, w);
        step(1, 1, 0, 10'd0, 1, 0, 10'd5, w);
        step(1, 0, 0, 10'd0, 1, 0, 10'd5, w);
        // single read by master 0
        step(1, 1, 0, 10'd0, 0, 0, 10'd0, w);
        // pipelined burst by master 1
        for (int i = 0; i < 4; i++) step(1, 0, 0, 10'd0, 1, 0, 10'(i), w);
        step(1, 0, 0, 10'd0, 0, 0, 10'd0, w);
        // round-robin, no lock
        for (int i = 0; i < 8; i++)
            step(1, 1, 0, 10'($urandom_range(1023)), 1, 0, 10'($urandom_range(1023)), w);
        // lock cap with master 0 locked
        for (int i = 0; i < 12; i++)
            step(1, 1, 1, 10'(4 + i), 1, 0, 10'(100 + i), w);
        // uncontested lock saturates, then holder stops and master 1 gets in
        for (int i = 0; i < 6; i++) step(1, 1, 1, 10'(i), 0, 0, 10'd0, w);
        step(1, 0, 0, 10'd0, 1, 0, 10'd9, w);
        // reset asserted in the cycle after an accept
        step(1, 1, 0, 10'd1, 0, 0, 10'd0, w);
        step(0, 0, 0, 10'd0, 0, 0, 10'd0, w);
        step(0, 1, 0, 10'd2, 1, 0, 10'd3, w);
        step(1, 1, 0, 10'd2, 1, 0, 10'd3, w);
        step(1, 1, 0, 10'd2, 1, 0, 10'd3, w);
        step(1, 0, 0, 10'd2, 1, 0, 10'd3, w);

        // random traffic obeying the hold-until-grant protocol
        hr0 = 0; hl0 = 0; ha0 = '0; hr1 = 0; hl1 = 0; ha1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!hr0 && $urandom_range(9) < 7) begin
                hr0 = 1;
                hl0 = ($urandom_range(9) < 4);
                ha0 = ($urandom_range(3) == 0) ? 10'($urandom_range(7)) : 10'($urandom_range(1023));
            end
            if (!hr1 && $urandom_range(9) < 7) begin
                hr1 = 1;
                hl1 = ($urandom_range(9) < 4);
                ha1 = ($urandom_range(3) == 0) ? 10'($urandom_range(7)) : 10'($urandom_range(1023));
            end
            step(1, hr0, hr0 & hl0, ha0, hr1, hr1 & hl1, ha1, w);
            if (w == 0) hr0 = 0;
            if (w == 1) hr1 = 0;
        end
        for (int i = 0; i < 3; i++) step(1, 0, 0, 10'd0, 0, 0, 10'd0, w);
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
